// File: rtl/div_arbiter_if.sv
// Handshake and bus bundle between requesters, div_arbiter and the shared divider.
// The rsp_dz signal exists only when DIV_ARB_DZ_EN is defined.
interface div_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_dividend;
    logic [NREQ*32-1:0] req_divisor;
    logic [NREQ-1:0]    req_sign;
    logic [31:0]        div_dividend;
    logic [31:0]        div_divider;
    logic               div_sign;
    logic               div_ready;
    logic [31:0]        div_quotient;
    logic [31:0]        div_remainder;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_quotient;
    logic [31:0]        rsp_remainder;
`ifdef DIV_ARB_DZ_EN
    logic               rsp_dz;
`endif

    modport slave (
        input  req_valid, req_dividend, req_divisor, req_sign,
        input  div_ready, div_quotient, div_remainder, rsp_ready,
        output req_ready, div_dividend, div_divider, div_sign,
        output rsp_valid, rsp_id, rsp_quotient, rsp_remainder
`ifdef DIV_ARB_DZ_EN
        , output rsp_dz
`endif
    );

    modport master (
        output req_valid, req_dividend, req_divisor, req_sign,
        output div_ready, div_quotient, div_remainder, rsp_ready,
        input  req_ready, div_dividend, div_divider, div_sign,
        input  rsp_valid, rsp_id, rsp_quotient, rsp_remainder
`ifdef DIV_ARB_DZ_EN
        , input rsp_dz
`endif
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one iterative divider among NREQ requesters, with a
// 2-entry tagged response FIFO. Define DIV_ARB_DZ_EN to add divide-by-zero reporting.
module div_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    div_arbiter_if.slave  bus
);

`ifdef DIV_ARB_DZ_EN
    localparam int EW = IDW + 65;
`else
    localparam int EW = IDW + 64;
`endif

    logic [31:0]    dividend_a [NREQ];
    logic [31:0]    divisor_a  [NREQ];
    logic [IDW-1:0] last_r;
    logic [IDW-1:0] inflight_id_r;
    logic           inflight_r;
    logic [1:0]     cnt_r;
    logic [EW-1:0]  head_r;
    logic [EW-1:0]  tail_r;
    logic [EW-1:0]  cmp_s;
    logic [IDW-1:0] cand_s;
    logic [IDW-1:0] gnt_s;
    logic           take_s;
    logic           found_s;
    logic           pop_s;
    logic           push_s;
    logic [2:0]     resv_s;
    logic           grant_s;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign dividend_a[g] = bus.req_dividend[g*32 +: 32];
        assign divisor_a[g]  = bus.req_divisor[g*32 +: 32];
    end

    // Round-robin search starting just after the most recently granted requester.
    always_comb begin
        found_s = 1'b0;
        gnt_s   = '0;
        cand_s  = '0;
        take_s  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s  = IDW'((int'(last_r) + k) % NREQ);
            take_s  = !found_s && bus.req_valid[cand_s];
            gnt_s   = take_s ? cand_s : gnt_s;
            found_s = found_s | take_s;
        end
    end

    // The in-flight result already owns a FIFO slot, so it counts against the credit.
    assign pop_s   = (cnt_r != 2'd0) && bus.rsp_ready;
    assign push_s  = bus.div_ready && inflight_r;
    assign resv_s  = {1'b0, cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign grant_s = !rst && bus.div_ready && found_s && (resv_s < 3'd2);

    assign bus.req_ready    = grant_s ? (NREQ'(1) << gnt_s) : '0;
    assign bus.div_dividend = grant_s ? dividend_a[gnt_s] : 32'd0;
    assign bus.div_divider  = grant_s ? divisor_a[gnt_s]  : 32'd0;
    assign bus.div_sign     = grant_s ? bus.req_sign[gnt_s] : 1'b0;

`ifdef DIV_ARB_DZ_EN
    logic        inflight_dz_r;
    logic [31:0] inflight_dvd_r;

    // Remember whether the launched operation divides by zero, and its dividend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_dz_r  <= 1'b0;
            inflight_dvd_r <= 32'd0;
        end else if (grant_s) begin
            inflight_dz_r  <= (divisor_a[gnt_s] == 32'd0);
            inflight_dvd_r <= dividend_a[gnt_s];
        end
    end

    assign cmp_s = {inflight_id_r, inflight_dz_r,
                    inflight_dz_r ? 32'hFFFF_FFFF : bus.div_quotient,
                    inflight_dz_r ? inflight_dvd_r : bus.div_remainder};
    assign bus.rsp_dz = head_r[64];
`else
    assign cmp_s = {inflight_id_r, bus.div_quotient, bus.div_remainder};
`endif

    assign bus.rsp_valid     = (cnt_r != 2'd0);
    assign bus.rsp_id        = head_r[EW-1 -: IDW];
    assign bus.rsp_quotient  = head_r[63:32];
    assign bus.rsp_remainder = head_r[31:0];

    // Launch bookkeeping: only a ready window can start or drop an operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_r    <= 1'b0;
            inflight_id_r <= '0;
            last_r        <= IDW'(NREQ - 1);
        end else if (bus.div_ready) begin
            inflight_r <= grant_s;
            if (grant_s) begin
                inflight_id_r <= gnt_s;
                last_r        <= gnt_s;
            end
        end
    end

    // Two-slot FIFO whose head register drives the response outputs directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= 2'd0;
            head_r <= '0;
            tail_r <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (cnt_r == 2'd0) head_r <= cmp_s;
                    else               tail_r <= cmp_s;
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    head_r <= tail_r;
                    cnt_r  <= cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        head_r <= cmp_s;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= cmp_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Randomized scoreboard bench for div_arbiter with a free-running divider model.
module tb_div_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           dz;
        logic [31:0]    q;
        logic [31:0]    r;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    div_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
    div_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference divider arithmetic; divide by zero yields a fixed garbage pattern.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {32'h5A5A_5A5A, 32'hA5A5_A5A5};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    // Divider model: 33-edge period, samples at the ready edge, result shown in next window.
    int          ph = 0;
    logic [31:0] dq = 32'd0;
    logic [31:0] dr = 32'd0;
    assign bus.div_ready     = (ph == 32);
    assign bus.div_quotient  = bus.div_ready ? dq : 32'hDEAD_BEEF;
    assign bus.div_remainder = bus.div_ready ? dr : 32'hBEEF_DEAD;
    always @(posedge clk) begin
        ph <= (ph == 32) ? 0 : ph + 1;
        if (ph == 32) {dq, dr} <= ref_div(bus.div_dividend, bus.div_divider, bus.div_sign);
    end

    // Scoreboard state owned by the monitor.
    exp_t exp_q[$];
    int   outstanding = 0;
    int   last_g = NREQ - 1;
    int   n_grant = 0;
    int   n_rsp = 0;

    initial begin
        exp_t            e;
        logic            pop;
        int              g;
        int              c;
        logic [NREQ-1:0] exp_rdy;
        logic [31:0]     a, b;
        logic [63:0]     res;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                outstanding = 0;
                last_g = NREQ - 1;
                n_grant = 0;
                n_rsp = 0;
                chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
                chk("rst_req_ready", {60'd0, bus.req_ready}, 64'd0);
            end else begin
                pop = bus.rsp_valid && bus.rsp_ready;
                if (pop) begin
                    n_rsp++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: got id %0d q %h with no expected entry",
                                 bus.rsp_id, bus.rsp_quotient);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_id", {62'd0, bus.rsp_id}, {62'd0, e.id});
                        chk("rsp_qr", {bus.rsp_quotient, bus.rsp_remainder}, {e.q, e.r});
`ifdef DIV_ARB_DZ_EN
                        chk("rsp_dz", {63'd0, bus.rsp_dz}, {63'd0, e.dz});
`endif
                    end
                end
                if (bus.div_ready) begin
                    g = -1;
                    if (outstanding - int'(pop) < 2) begin
                        for (int k = 1; k <= NREQ; k++) begin
                            c = (last_g + k) % NREQ;
                            if (g < 0 && bus.req_valid[c]) g = c;
                        end
                    end
                    exp_rdy = '0;
                    if (g >= 0) exp_rdy[g] = 1'b1;
                    chk("grant", {60'd0, bus.req_ready}, {60'd0, exp_rdy});
                    if (g >= 0) begin
                        a = bus.req_dividend[g*32 +: 32];
                        b = bus.req_divisor[g*32 +: 32];
                        chk("div_operands", {bus.div_dividend, bus.div_divider}, {a, b});
                        chk("div_sign", {63'd0, bus.div_sign}, {63'd0, bus.req_sign[g]});
                        res = ref_div(a, b, bus.req_sign[g]);
                        e.id = IDW'(g);
                        e.dz = 1'b0;
                        e.q = res[63:32];
                        e.r = res[31:0];
`ifdef DIV_ARB_DZ_EN
                        if (b == 32'd0) begin
                            e.dz = 1'b1;
                            e.q = 32'hFFFF_FFFF;
                            e.r = a;
                        end
`endif
                        exp_q.push_back(e);
                        outstanding++;
                        n_grant++;
                        last_g = g;
                    end else begin
                        chk("idle_operands", {bus.div_dividend, bus.div_divider},
                            {31'd0, bus.div_sign, 32'd0});
                    end
                end else begin
                    chk("no_window_grant", {60'd0, bus.req_ready}, 64'd0);
                end
                if (pop) outstanding--;
            end
        end
    end

    // Stimulus side.
    logic [NREQ-1:0] acc_last = '0;
    logic [NREQ-1:0] refill = '0;
    bit              rand_mode = 0;

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.req_valid[i] = 1'b1;
        bus.req_dividend[i*32 +: 32] = a;
        bus.req_divisor[i*32 +: 32] = b;
        bus.req_sign[i] = s;
    endtask

    task automatic new_req(input int i);
        logic [31:0] a, b;
        logic        s;
        a = $urandom;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = $urandom_range(1, 9);
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: b = $urandom;
        endcase
        set_req(i, a, b, s);
    endtask

    task automatic step();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        acc = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        acc_last = acc;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                if (refill[i]) new_req(i);
                else bus.req_valid[i] = 1'b0;
            end else if (rand_mode && !bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
                new_req(i);
            end
        end
        if (rand_mode) bus.rsp_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        refill = '0;
        rand_mode = 0;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        rand_mode = 0;
        refill = '0;
        bus.rsp_ready = 1'b1;
        for (int t = 0; t < 800 && !done; t++) begin
            step();
            done = (bus.req_valid == '0) && (outstanding == 0) && !bus.rsp_valid;
        end
        chk("drain_done", {63'd0, done}, 64'd1);
        chk("rsp_count", 64'(n_rsp), 64'(n_grant));
    endtask

    task automatic run_one(input int id, input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] eq, input logic [31:0] er, input logic edz);
        bit got;
        int acc_cyc;
        bus.rsp_ready = 1'b1;
        set_req(id, a, b, s);
        got = 0;
        for (int t = 0; t < 80 && !got; t++) begin
            step();
            got = acc_last[id];
        end
        chk("accept", {63'd0, got}, 64'd1);
        acc_cyc = cyc;
        got = 0;
        for (int t = 0; t < 80 && !got; t++) begin
            step();
            got = bus.rsp_valid;
        end
        chk("rsp_seen", {63'd0, got}, 64'd1);
        chk("latency", 64'(cyc - acc_cyc), 64'd33);
        chk("one_id", {62'd0, bus.rsp_id}, 64'(id));
        chk("one_qr", {bus.rsp_quotient, bus.rsp_remainder}, {eq, er});
`ifdef DIV_ARB_DZ_EN
        chk("one_dz", {63'd0, bus.rsp_dz}, {63'd0, edz});
`else
        if (edz) $display("note: dz expectation ignored in this build");
`endif
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          order[$];
        int          exp_order[5];
        int          cnt;
        int          seen;
        bit          got;
        bit          reissued;
        logic [95:0] snap;
        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_dividend = '0;
        bus.req_divisor = '0;
        bus.req_sign = '0;
        bus.rsp_ready = 1'b1;

        do_reset();
        chk("reset_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("reset_rsp_id", {62'd0, bus.rsp_id}, 64'd0);
        chk("reset_rsp_qr", {bus.rsp_quotient, bus.rsp_remainder}, 64'd0);

        run_one(0, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        run_one(2, 32'hFFFF_FFF8, 32'd2, 1'b1, 32'hFFFF_FFFC, 32'd0, 1'b0);

        // Everyone requests from reset; requester 0 asks again right after its grant.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(1000 * (i + 1) + 7), 32'(i + 3), 1'b0);
        reissued = 0;
        for (int t = 0; t < 400 && order.size() < 5; t++) begin
            step();
            for (int i = 0; i < NREQ; i++) if (acc_last[i]) order.push_back(i);
            if (acc_last[0] && !reissued) begin
                set_req(0, 32'd4242, 32'd5, 1'b0);
                reissued = 1;
            end
        end
        chk("order_len", 64'(order.size()), 64'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) chk("grant_order", 64'(order[i]), 64'(exp_order[i]));
        drain();

        // Consumer stalled with continuous requests: only two operations may be launched.
        do_reset();
        bus.rsp_ready = 1'b0;
        refill = '1;
        for (int i = 0; i < NREQ; i++) new_req(i);
        cnt = 0;
        for (int t = 0; t < 170; t++) begin
            step();
            for (int i = 0; i < NREQ; i++) if (acc_last[i]) cnt++;
        end
        chk("hold_grants", 64'(cnt), 64'd2);
        chk("hold_valid", {63'd0, bus.rsp_valid}, 64'd1);
        snap = {30'd0, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder};
        repeat (10) step();
        chk("hold_stable", snap[63:0], {bus.rsp_quotient, bus.rsp_remainder});
        chk("hold_stable_id", {32'd0, snap[95:64]}, {62'd0, bus.rsp_id});
        bus.rsp_ready = 1'b1;
        repeat (150) step();
        drain();

        // Randomized traffic with random back-pressure.
        do_reset();
        rand_mode = 1;
        repeat (1500) step();
        drain();

        // Reset ten cycles after a grant: the dropped operation must never reappear.
        bus.rsp_ready = 1'b1;
        set_req(1, 32'd1000, 32'd10, 1'b0);
        got = 0;
        for (int t = 0; t < 80 && !got; t++) begin
            step();
            got = acc_last[1];
        end
        chk("rst_accept", {63'd0, got}, 64'd1);
        repeat (10) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        seen = 0;
        for (int t = 0; t < 70; t++) begin
            step();
            if (bus.rsp_valid) seen++;
        end
        chk("stale_rsp", 64'(seen), 64'd0);
        run_one(3, 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);

`ifdef DIV_ARB_DZ_EN
        run_one(0, 32'd55, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd55, 1'b1);
        run_one(1, 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
